// File: rtl/univ_register_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : univ_register_if
// Brief    : Control/data bundle between a requester and univ_register.
//            The master drives the operation requests, the slave returns the
//            register value and status flags.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface univ_register_if #(
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(WIDTH) + 1
) ();

  // Operation requests
  logic             cl;
  logic             ld;
  logic [WIDTH-1:0] in;
  logic             inc;
  logic             dec;
  logic             sr;
  logic             ir;
  logic             sl;
  logic             il;
  logic             rot;
  logic             ms_start;
  logic             ms_dir;
  logic [AW-1:0]    ms_amt;

  // Register value and status
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output cl, ld, in, inc, dec, sr, ir, sl, il, rot, ms_start, ms_dir, ms_amt,
    input  out, carry, zero, busy, done
  );

  modport slave (
    input  cl, ld, in, inc, dec, sr, ir, sl, il, rot, ms_start, ms_dir, ms_amt,
    output out, carry, zero, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/univ_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : univ_register
// Brief    : Universal register: clear, load, inc/dec (wrap or saturate),
//            single-bit shifts/rotates and a multi-cycle shift sequencer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module univ_register #(
  parameter int WIDTH = 4,
  parameter int SAT   = 0,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input wire             clk,
  input wire             rst,
  univ_register_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [AW-1:0]    cnt_q;
  logic             dir_q;
  logic             rot_q;
  logic             ir_q;
  logic             il_q;

  // Candidate results, each packed as {carry, value}
  logic [WIDTH:0]   inc_d;
  logic [WIDTH:0]   dec_d;
  logic [WIDTH:0]   sr_d;
  logic [WIDTH:0]   sl_d;
  logic [WIDTH:0]   ms_d;
  logic [AW-1:0]    amt_d;

  // One-bit shift returning {shifted-out bit, new value}; rot recirculates
  // the outgoing bit instead of taking the serial input.
  function automatic logic [WIDTH:0] shift1(
    input logic [WIDTH-1:0] v,
    input logic             left,
    input logic             rot,
    input logic             fill_r,
    input logic             fill_l
  );
    logic fill;
    if (left) begin
      fill = rot ? v[WIDTH-1] : fill_l;
      return {v[WIDTH-1], v[WIDTH-2:0], fill};
    end else begin
      fill = rot ? v[0] : fill_r;
      return {v[0], fill, v[WIDTH-1:1]};
    end
  endfunction

  // Next-value candidates for every operation; the FSM picks one.
  always_comb begin
    inc_d = {1'b0, out_q} + {{WIDTH{1'b0}}, 1'b1};
    dec_d = {1'b0, out_q} - {{WIDTH{1'b0}}, 1'b1};
    // The extra top bit flags wrap (carry out of all-ones / borrow from 0);
    // saturating mode keeps the old value but still reports the flag.
    if (SAT != 0 && inc_d[WIDTH]) begin
      inc_d = {1'b1, out_q};
    end
    if (SAT != 0 && dec_d[WIDTH]) begin
      dec_d = {1'b1, out_q};
    end
    sr_d  = shift1(out_q, 1'b0, bus.rot, bus.ir, bus.il);
    sl_d  = shift1(out_q, 1'b1, bus.rot, bus.ir, bus.il);
    ms_d  = shift1(out_q, dir_q, rot_q, ir_q, il_q);
    amt_d = (bus.ms_amt > AW'(WIDTH)) ? AW'(WIDTH) : bus.ms_amt;
  end

  // Operation sequencer: priority select in IDLE, multi-shift in SHIFT,
  // single dead cycle in DONE; busy/done are registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      ir_q    <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cl) begin
            out_q   <= '0;
            carry_q <= 1'b0;
          end else if (bus.ld) begin
            out_q   <= bus.in;
            carry_q <= 1'b0;
          end else if (bus.ms_start) begin
            dir_q <= bus.ms_dir;
            rot_q <= bus.rot;
            ir_q  <= bus.ir;
            il_q  <= bus.il;
            cnt_q <= amt_d;
            // A zero-length request still produces its done pulse.
            if (amt_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
            end
          end else if (bus.inc) begin
            out_q   <= inc_d[WIDTH-1:0];
            carry_q <= inc_d[WIDTH];
          end else if (bus.dec) begin
            out_q   <= dec_d[WIDTH-1:0];
            carry_q <= dec_d[WIDTH];
          end else if (bus.sr) begin
            out_q   <= sr_d[WIDTH-1:0];
            carry_q <= sr_d[WIDTH];
          end else if (bus.sl) begin
            out_q   <= sl_d[WIDTH-1:0];
            carry_q <= sl_d[WIDTH];
          end
        end

        S_SHIFT: begin
          if (bus.cl) begin
            // Abort: clear and drop straight back without a done pulse.
            out_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            out_q   <= ms_d[WIDTH-1:0];
            carry_q <= ms_d[WIDTH];
            cnt_q   <= cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.zero  = (out_q == '0);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: doc/univ_register.md
UNIV_REGISTER -- requirements
Module: univ_register

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- WIDTH, 4, register width in bits (>=2).
- SAT, 0, arithmetic mode: 0 = wrap, 1 = saturate.
- AW, $clog2(WIDTH)+1, width of the multi-shift amount field.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- cl, input, 1, synchronous clear.
- ld, input, 1, parallel load of in.
- in, input, WIDTH, parallel load data.
- inc, input, 1, increment.
- dec, input, 1, decrement.
- sr, input, 1, single-cycle shift right; ir is the serial input into the MSB.
- ir, input, 1, serial input into the MSB on a right shift.
- sl, input, 1, single-cycle shift left; il is the serial input into the LSB.
- il, input, 1, serial input into the LSB on a left shift.
- rot, input, 1, rotate mode for shifts; replaces ir/il with the wrapped-out bit.
- ms_start, input, 1, start a multi-cycle shift.
- ms_dir, input, 1, multi-shift direction: 0 = right, 1 = left.
- ms_amt, input, AW, multi-shift bit count.
- out, output, WIDTH, register value.
- carry, output, 1, carry/borrow/shifted-out flag.
- zero, output, 1, combinational: high when out == 0.
- busy, output, 1, high while a multi-shift is in progress.
- done, output, 1, one-cycle pulse at multi-shift completion.

Function
REQ-003 The FSM SHALL have three states: IDLE, SHIFT and DONE. busy SHALL be high only in SHIFT, and done SHALL be high only in DONE.

REQ-004 In IDLE, exactly one operation SHALL execute per cycle, chosen by fixed priority: cl > ld > ms_start > inc > dec > sr > sl. With no request asserted, out and carry SHALL hold.

REQ-005 cl SHALL set out=0 and carry=0. ld SHALL set out=in and carry=0.

REQ-006 inc with SAT=0 SHALL set out=out+1 mod 2^WIDTH, and carry SHALL be 1 exactly when the value wraps from all-ones; with SAT=1, inc on all-ones SHALL hold out and set carry=1.

REQ-007 dec with SAT=0 SHALL set out=out-1 mod 2^WIDTH, and carry SHALL be 1 exactly when the value wraps from 0; with SAT=1, dec on 0 SHALL hold out at 0 and set carry=1.

REQ-008 sr SHALL shift right one bit, filling the MSB with ir (or with out[0] when rot=1), and carry SHALL take the bit shifted out (out[0]). sl SHALL behave symmetrically: fill the LSB with il (or out[WIDTH-1] when rot=1), and carry SHALL take out[WIDTH-1].

REQ-009 ms_start accepted in IDLE SHALL latch ms_dir, rot, ir/il and a remaining count of min(ms_amt, WIDTH), and SHALL enter SHIFT on the next edge; if the latched count is 0, it SHALL go directly to DONE with out unchanged.

REQ-010 In SHIFT, each cycle SHALL perform one shift using the latched controls with per-bit carry as in REQ-008 and decrement the count; after the last shift the FSM SHALL enter DONE, so latency from ms_start to done is count+1 cycles.

REQ-011 DONE SHALL last exactly one cycle, return to IDLE and accept no request in that cycle.

REQ-012 While busy, ld, ms_start, inc, dec, sr and sl SHALL be ignored; cl SHALL abort: out=0, carry=0, next state IDLE, and no done pulse.

REQ-013 zero SHALL reflect out combinationally with no added latency.

Reset
REQ-014 On rst high, asynchronously and independent of clk: out=0, carry=0, busy=0, done=0, FSM=IDLE, latched count=0.

REQ-015 rst asserted mid-multi-shift SHALL abandon the operation with no done pulse; the first edge after rst deassertion SHALL process inputs normally from IDLE.

Verification
REQ-016 With WIDTH=4, the bench SHALL cover these scenarios (stimulus -> required response):
- Priority: cl=ld=inc=1, in=4'hA -> out=0; then ld=inc=1, in=4'hA -> out=4'hA.
- Overflow, SAT=0: out=4'hF, inc -> out=0, carry=1, zero=1. Same with SAT=1 -> out=4'hF, carry=1.
- Underflow, SAT=0: out=0, dec -> out=4'hF, carry=1. Same with SAT=1 -> out=0, carry=1.
- Rotate: out=4'b1001, rot=1, ms_start, ms_dir=0, ms_amt=2 -> busy for 2 cycles, then done pulse for 1 cycle; out=4'b0110, carry=0.
- Shift edge cases: ms_amt=0 -> done one cycle after start, out unchanged; ms_amt=7 -> clamped to 4 shifts.
- Abort: cl during SHIFT -> out=0, busy=0 next cycle, no done pulse. rst during SHIFT -> immediate out=0, busy=0.
